// File: rtl/bm_port_pkg.sv
//==============================================================================
// Module   : bm_port_pkg
// Purpose  : Shared constants and helpers for BondMachine port adapters.
// Revision : 1.0
//==============================================================================
`default_nettype none

package bm_port_pkg;

  localparam int c_default_width = 8;
  localparam int c_default_depth = 4;

  localparam logic IDLE = 1'b0;
  localparam logic ACK  = 1'b1;

  function automatic logic [31:0] ptr_next(input logic [31:0] ptr, input int unsigned depth);
    return (ptr + 32'd1) % depth;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bm_sync_fifo.sv
//==============================================================================
// Module   : bm_sync_fifo
// Purpose  : Single-clock FIFO with occupancy count, no full/empty bypass.
// Revision : 1.0
//==============================================================================
`default_nettype none

module bm_sync_fifo
  import bm_port_pkg::*;
#(
  parameter  int WIDTH = c_default_width,
  parameter  int DEPTH = c_default_depth,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic [AW:0]      o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam logic [AW:0] c_count_one  = (AW+1)'(1);
  localparam logic [AW:0] c_count_full = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // Flags come straight from the registered count so they never glitch.
  assign o_full    = (r_count == c_count_full);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_push    = i_push && !o_full;
  assign w_pop     = i_pop && !o_empty;
  assign o_rd_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= AW'(ptr_next(32'(r_wr_ptr), DEPTH));
      if (w_pop)  r_rd_ptr <= AW'(ptr_next(32'(r_rd_ptr), DEPTH));
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_count_one;
        2'b01:   r_count <= r_count - c_count_one;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/bm_oport_receiver.sv
//==============================================================================
// Module   : bm_oport_receiver
// Purpose  : Consumes a processor output port and re-presents it via a FIFO.
// Revision : 1.0
//==============================================================================
`default_nettype none

module bm_oport_receiver
  import bm_port_pkg::*;
#(
  parameter  int WIDTH = c_default_width,
  parameter  int DEPTH = c_default_depth,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock_signal,
  input  logic             reset_signal,
  input  logic [WIDTH-1:0] i0,
  input  logic             i0_valid,
  output logic             i0_received,
  output logic [WIDTH-1:0] o0,
  output logic             o0_valid,
  input  logic             o0_received,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic r_state;
  logic r_received;
  logic w_push;
  logic w_full;
  logic w_empty;

  // ACK is a dead cycle: the producer drops valid on that same edge.
  assign w_push = (r_state == IDLE) && i0_valid && !w_full;

  always_ff @(posedge clock_signal or negedge reset_signal) begin
    if (!reset_signal) begin
      r_state    <= IDLE;
      r_received <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_push) begin
            r_state    <= ACK;
            r_received <= 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_received <= 1'b0;
        end
      endcase
    end
  end

  bm_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clock_signal),
    .rst_n     (reset_signal),
    .i_push    (w_push),
    .i_wr_data (i0),
    .i_pop     (o0_received),
    .o_rd_data (o0),
    .o_count   (count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign i0_received = r_received;
  assign full        = w_full;
  assign empty       = w_empty;
  assign o0_valid    = !w_empty;

endmodule

`default_nettype wire

// File: tb/tb_bm_oport_receiver.sv
//==============================================================================
// Module   : tb_bm_oport_receiver
// Purpose  : Directed self-checking bench for bm_oport_receiver.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_bm_oport_receiver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] i0 = '0;
  logic       i0_valid = 1'b0;
  logic       i0_received;
  logic [7:0] o0;
  logic       o0_valid;
  logic       o0_received = 1'b0;
  logic [2:0] count;
  logic       full;
  logic       empty;

  int checks = 0;
  int failures = 0;
  int waited;
  logic [7:0] exp_q[$];
  logic [7:0] exp_word;
  logic [7:0] drain_exp [4];

  always #5 clk = ~clk;

  bm_oport_receiver #(
    .WIDTH (8),
    .DEPTH (4)
  ) dut (
    .clock_signal (clk),
    .reset_signal (rst_n),
    .i0           (i0),
    .i0_valid     (i0_valid),
    .i0_received  (i0_received),
    .o0           (o0),
    .o0_valid     (o0_valid),
    .o0_received  (o0_received),
    .count        (count),
    .full         (full),
    .empty        (empty)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Producer: hold valid until received is seen at an edge, then drop it.
  task automatic send_word(input logic [7:0] d, input int budget, output int n);
    logic got;
    got = 1'b0;
    n = 0;
    i0 = d;
    i0_valid = 1'b1;
    while (!got && n < budget) begin
      tick();
      n++;
      if (i0_received) got = 1'b1;
    end
    i0_valid = 1'b0;
    chk("send_ack", got, 1);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_received", i0_received, 0);
    chk("rst_o0_valid", o0_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    rst_n = 1'b1;

    // Single word
    send_word(8'hA5, 8, waited);
    chk("t1_latency", waited, 1);
    chk("t1_o0", o0, 8'hA5);
    chk("t1_o0_valid", o0_valid, 1);
    chk("t1_count", count, 1);
    tick();
    chk("t1_ack_drop", i0_received, 0);
    chk("t1_count_hold", count, 1);
    o0_received = 1'b1;
    tick();
    o0_received = 1'b0;
    chk("t1_drain_count", count, 0);
    chk("t1_drain_empty", empty, 1);

    // Burst fill
    send_word(8'h01, 8, waited);
    chk("t2_lat01", waited, 1);
    send_word(8'h02, 8, waited);
    chk("t2_lat02", waited, 2);
    send_word(8'h03, 8, waited);
    chk("t2_lat03", waited, 2);
    send_word(8'h04, 8, waited);
    chk("t2_lat04", waited, 2);
    chk("t2_full", full, 1);
    chk("t2_count", count, 4);
    i0 = 8'h05;
    i0_valid = 1'b1;
    tick();
    tick();
    tick();
    chk("t2_stall_received", i0_received, 0);
    chk("t2_stall_count", count, 4);
    chk("t2_stall_head", o0, 8'h01);

    // Drain one while the producer is stalled
    o0_received = 1'b1;
    tick();
    o0_received = 1'b0;
    chk("t3_head", o0, 8'h02);
    chk("t3_full", full, 0);
    chk("t3_count", count, 3);
    chk("t3_no_capture", i0_received, 0);
    tick();
    chk("t3_capture05", i0_received, 1);
    chk("t3_count_refill", count, 4);
    i0_valid = 1'b0;
    drain_exp[0] = 8'h02;
    drain_exp[1] = 8'h03;
    drain_exp[2] = 8'h04;
    drain_exp[3] = 8'h05;
    o0_received = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_order", o0, drain_exp[i]);
      tick();
    end
    o0_received = 1'b0;
    chk("t3_empty", empty, 1);

    // Simultaneous push/pop at count 2, across several wraps
    send_word(8'h10, 8, waited);
    exp_q.push_back(8'h10);
    send_word(8'h11, 8, waited);
    exp_q.push_back(8'h11);
    tick();
    chk("t4_count_start", count, 2);
    for (int k = 0; k < 10; k++) begin
      i0 = 8'h20 + 8'(k);
      i0_valid = 1'b1;
      o0_received = 1'b1;
      exp_q.push_back(i0);
      exp_word = exp_q.pop_front();
      chk("t4_head", o0, exp_word);
      tick();
      chk("t4_count", count, 2);
      chk("t4_received", i0_received, 1);
      i0_valid = 1'b0;
      o0_received = 1'b0;
      tick();
    end
    o0_received = 1'b1;
    exp_word = exp_q.pop_front();
    chk("t4_tail0", o0, exp_word);
    tick();
    exp_word = exp_q.pop_front();
    chk("t4_tail1", o0, exp_word);
    tick();
    o0_received = 1'b0;
    chk("t4_empty", empty, 1);

    // Asynchronous reset during ACK
    send_word(8'h77, 8, waited);
    chk("t5_pre_count", count, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_received", i0_received, 0);
    chk("t5_async_o0_valid", o0_valid, 0);
    chk("t5_async_count", count, 0);
    tick();
    tick();
    rst_n = 1'b1;
    send_word(8'h3C, 8, waited);
    chk("t5_relatency", waited, 1);
    chk("t5_o0", o0, 8'h3C);
    chk("t5_count", count, 1);
    tick();
    o0_received = 1'b1;
    tick();
    o0_received = 1'b0;
    chk("t5_drain", count, 0);

    // Pops while empty are ignored
    o0_received = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_o0_valid", o0_valid, 0);
      chk("t6_count", count, 0);
      chk("t6_empty", empty, 1);
    end
    o0_received = 1'b0;
    send_word(8'h5A, 8, waited);
    chk("t6_after_o0", o0, 8'h5A);
    chk("t6_after_count", count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bm_oport_receiver.md
Name: bm_oport_receiver

Overview:
- Consumer end of the BondMachine processor output-port handshake (data, valid, received).
- Accepts words a processor emits via R2O, acknowledges each with a one-cycle received pulse, and buffers them in a small FIFO.
- Re-presents the buffered words on a downstream port with the same data/valid/received protocol, so it can feed a processor input port, an LED/UART sink, or a second stage.
- Sits between a processor's oN port and bondmachine-level glue.

Parameters:
- WIDTH, 8, data width of both ports (1..32).
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clock_signal  in  1  single clock; all state on rising edge.
- reset_signal  in  1  asynchronous, active-low reset.
- i0  in  WIDTH  upstream data from the processor output port.
- i0_valid  in  1  upstream valid; the producer holds it high until it sees received high at a clock edge.
- i0_received  out  1  registered acknowledge pulse to the producer.
- o0  out  WIDTH  head-of-FIFO data.
- o0_valid  out  1  high when the FIFO is non-empty.
- o0_received  in  1  downstream acknowledge; pops the head word.
- count  out  AW+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset (reset_signal=0, asynchronous):
  - i0_received=0, rd_ptr=0, wr_ptr=0, count=0, o0_valid=0, empty=1, full=0.
  - Storage contents are don't-care; o0 is don't-care while o0_valid=0.
  - A reset asserted mid-transfer drops all buffered words and any pending acknowledge.
  - Release is synchronous to the next edge; the first capture is possible on the first edge after release.
- Upstream FSM, two states, IDLE and ACK:
  - IDLE: when i0_valid=1 and full=0 at an edge, write i0 to mem[wr_ptr], increment wr_ptr (wraps modulo DEPTH), set i0_received<=1, go to ACK.
  - IDLE: when i0_valid=1 and full=1, stay in IDLE with i0_received=0. The producer stalls, holding valid; no data is lost or overwritten.
  - ACK: i0_received=1 for exactly this cycle. At the next edge return to IDLE with i0_received<=0. No capture in ACK, even if i0_valid is still high, because the producer clears valid on this same edge.
  - Result: capture latency is 1 edge, acknowledge latency is 1 cycle, and peak upstream throughput is 1 word per 2 cycles.
  - If the producer re-issues R2O while valid is still high, the data is sampled at the capture edge. The last value presented before capture wins.
- Downstream:
  - o0 = mem[rd_ptr] (combinational read of registered storage); o0_valid = !empty.
  - Pop when o0_valid=1 and o0_received=1 at an edge: rd_ptr increments and wraps modulo DEPTH.
  - o0_received while empty is ignored; no pointer change.
  - o0_received held high pops one word per cycle.
- Occupancy:
  - Push only: count+1. Pop only: count-1. Push and pop on the same edge: count unchanged and both pointers advance.
  - Push is allowed when full=0 at the start of the cycle; there is no full-bypass.
  - Pop is allowed when empty=0 at the start of the cycle; there is no empty-bypass, so a word captured this edge is visible on o0 next cycle.
  - full, empty and o0_valid are derived from registered count, so they are glitch-free.
- All arithmetic is unsigned. Pointers are AW bits and wrap naturally; count is AW+1 bits and never exceeds DEPTH.

Decomposition:
- Shared package bm_port_pkg holds:
  - localparams IDLE=1'b0 and ACK=1'b1 for the handshake state;
  - a helper function for the pointer increment;
  - the default WIDTH and DEPTH constants, so future bm_iport_transmitter reuses them.
- One natural sub-module: bm_sync_fifo (storage, pointers, count, full/empty), instantiated once.
- The handshake FSM and port glue stay in bm_oport_receiver.

Test Plan:
- Reset then single word: i0=8'hA5 with valid high for 1 edge, then a producer model clears valid on received. Required: i0_received high exactly 1 cycle after capture; o0=8'hA5 and o0_valid=1 the following cycle; count=1.
- Burst fill, DEPTH=4, downstream idle: producer sends 01,02,03,04,05. Required: first four acknowledged at 2-cycle spacing; full=1 and count=4; 05 stalls with i0_received=0 while valid is held.
- Drain with stalled producer: from the full state, pulse o0_received once. Required: o0 advances 01→02; full drops; 05 is captured next edge; order at o0 is 02,03,04,05.
- Simultaneous push/pop at count=2: capture and pop on the same edge. Required: count stays 2; both pointers advance; data order is preserved across wrap after 8+ words.
- Async reset mid-ACK: assert reset_signal=0 between edges while i0_received=1. Required: i0_received, o0_valid and count go to 0 immediately, without a clock edge; after release, a new word 8'h3C is captured normally.
- Empty pop: o0_received=1 for 3 cycles with empty=1. Required: no state change, o0_valid stays 0, count stays 0.
